// File: rtl/logic_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_pkg
//  Description : Shared types and helpers for the logic gate checker. Holds
//                the checker FSM state encoding, the bit position of each
//                gate result inside the packed gate_out bus, and the golden
//                truth-table function.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int GATE_N = 7;

  // Bit position of each gate result inside gate_out
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int GATE_NOTA = 6;

  function automatic logic [GATE_N-1:0] gate_golden(input logic a, input logic b);
    logic [GATE_N-1:0] v;
    v            = '0;
    v[GATE_AND]  = a & b;
    v[GATE_OR]   = a | b;
    v[GATE_NAND] = ~(a & b);
    v[GATE_NOR]  = ~(a | b);
    v[GATE_XOR]  = a ^ b;
    v[GATE_XNOR] = ~(a ^ b);
    v[GATE_NOTA] = ~a;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_gate_checker_gate_compare.sv
`default_nettype none
// ============================================================================
//  Module      : gate_compare
//  Description : Combinational comparison of one sampled gate-bank vector
//                against the golden truth table.
//  Ports       : a, b      - sampled gate inputs
//                gate_out  - sampled gate results (c_and at bit 0)
//                match     - 1 when every bit is known and equals golden
//                diff      - golden XOR observed (1 marks a wrong bit)
//                ab_known  - 1 when both a and b are 0/1 (no X/Z)
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_compare
  import logic_gate_pkg::*;
(
  input  logic              a,
  input  logic              b,
  input  logic [GATE_N-1:0] gate_out,
  output logic              match,
  output logic [GATE_N-1:0] diff,
  output logic              ab_known
);

  logic [GATE_N-1:0] w_exp;
  logic              w_all_known;

  always_comb begin
    w_exp       = gate_golden(a, b);
    diff        = w_exp ^ gate_out;
    ab_known    = !$isunknown({a, b});
    w_all_known = !$isunknown({a, b, gate_out});
    // An unknown golden bit could case-equal an unknown observed bit, so
    // the known-ness check is needed on top of the case-equality.
    match       = w_all_known && (gate_out === w_exp);
  end

endmodule
`default_nettype wire

// File: rtl/logic_gate_checker.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_checker
//  Description : Self-checking scoreboard for the two-input gate bank. On each
//                in_valid strobe during a run, compares gate_out against the
//                golden truth table, counts passes/fails (saturating), tracks
//                {b,a} input coverage and a sticky error flag. The run ends
//                after NUM_VEC samples.
//  Ports       : clk, rst (sync, active-high), start (run pulse),
//                in_valid/a/b/gate_out (sample), busy/done (state),
//                pass_cnt/fail_cnt (CNT_W), cov_mask (4), err_sticky.
//  Option      : LOGIC_GATE_CHECKER_FAIL_LOG_EN adds first_fail_ab and
//                first_fail_diff capture ports and a per-fail sim message.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NUM_VEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic              a,
  input  logic              b,
  input  logic [GATE_N-1:0] gate_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [3:0]        cov_mask,
  output logic              err_sticky
`ifdef LOGIC_GATE_CHECKER_FAIL_LOG_EN
  ,
  output logic [1:0]        first_fail_ab,
  output logic [GATE_N-1:0] first_fail_diff
`endif
);

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [CNT_W-1:0]  samp_q, samp_d;
  logic [3:0]        cov_q, cov_d;
  logic              err_q, err_d;
  logic [1:0]        ffab_q, ffab_d;
  logic [GATE_N-1:0] ffdiff_q, ffdiff_d;

  logic              w_match;
  logic              w_ab_known;
  logic [GATE_N-1:0] w_diff;
  logic              w_accept;
  logic              w_pass;

  gate_compare u_cmp (
    .a        (a),
    .b        (b),
    .gate_out (gate_out),
    .match    (w_match),
    .diff     (w_diff),
    .ab_known (w_ab_known)
  );

  assign w_accept = (state_q == RUN) && in_valid;
  // match already implies a zero diff; the diff term keeps the pass decision
  // tied to the same vector that the failure capture records.
  assign w_pass   = w_match && (w_diff == '0);

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    samp_d   = samp_q;
    cov_d    = cov_q;
    err_d    = err_q;
    ffab_d   = ffab_q;
    ffdiff_d = ffdiff_q;

    case (state_q)
      IDLE, DONE: begin
        // A sample strobed together with start is not counted.
        if (start) begin
          state_d  = RUN;
          pass_d   = '0;
          fail_d   = '0;
          samp_d   = '0;
          cov_d    = '0;
          err_d    = 1'b0;
          ffab_d   = '0;
          ffdiff_d = '0;
        end
      end
      RUN: begin
        if (w_accept) begin
          samp_d = samp_q + 1'b1;
          if (w_pass) begin
            if (pass_q != c_cnt_max) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != c_cnt_max) fail_d = fail_q + 1'b1;
            if (!err_q) begin
              ffab_d   = {b, a};
              ffdiff_d = w_diff;
            end
            err_d = 1'b1;
          end
          if (w_ab_known) cov_d[{b, a}] = 1'b1;
          if (samp_q == c_last_idx) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      samp_q   <= '0;
      cov_q    <= '0;
      err_q    <= 1'b0;
      ffab_q   <= '0;
      ffdiff_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      samp_q   <= samp_d;
      cov_q    <= cov_d;
      err_q    <= err_d;
      ffab_q   <= ffab_d;
      ffdiff_q <= ffdiff_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign cov_mask   = cov_q;
  assign err_sticky = err_q;

`ifdef LOGIC_GATE_CHECKER_FAIL_LOG_EN
  assign first_fail_ab   = ffab_q;
  assign first_fail_diff = ffdiff_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && w_accept && !w_pass)
      $error("gate check fail t=%0t a=%b b=%b exp=%b gate_out=%b",
             $time, a, b, gate_golden(a, b), gate_out);
  end
`endif
`endif

endmodule
`default_nettype wire
